// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcode patterns, ALU operation codes,
// control-FSM states and instruction classes.
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // CBZ and B are identified by a prefix; the remaining low bits are don't-care.
    localparam logic [10:0] CBZ_MASK  = 11'b11111111000;
    localparam logic [10:0] CBZ_MATCH = 11'b10110100000;
    localparam logic [10:0] B_MASK    = 11'b11111100000;
    localparam logic [10:0] B_MATCH   = 11'b00010100000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_ADDR,
        S_MEM_RD,
        S_WB_LD,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_LD,
        CLS_ST,
        CLS_CBZ,
        CLS_B,
        CLS_ILL
    } iclass_e;

endpackage

// File: rtl/opcode_class.sv
// Combinational decoder from the 11-bit opcode field to an instruction class.
// Unrecognised encodings map to CLS_ILL.
module opcode_class
    import legv8_pkg::*;
(
    input  logic [10:0] opcode,
    output iclass_e     iclass
);

    always_comb begin
        iclass = CLS_ILL;
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
            iclass = CLS_R;
        else if (opcode == OP_LDUR)
            iclass = CLS_LD;
        else if (opcode == OP_STUR)
            iclass = CLS_ST;
        else if ((opcode & CBZ_MASK) == CBZ_MATCH)
            iclass = CLS_CBZ;
        else if ((opcode & B_MASK) == B_MATCH)
            iclass = CLS_B;
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle LEGv8 main control: sequences fetch/decode/execute/memory/write-back,
// handshakes with a variable-latency memory, counts retired instructions, traps on bad opcodes.
module main_control_fsm
    import legv8_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [10:0]         opcode,
    input  logic                Zero,
    input  logic                MemReady,
    output logic [1:0]          AluOp,
    output logic                AluSrc,
    output logic                Reg2Loc,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemToReg,
    output logic                RegWrite,
    output logic                IrWrite,
    output logic                PcWrite,
    output logic                PcSrc,
    output logic                Illegal,
    output logic [RETIRE_W-1:0] Retired
);

    state_e              state_q, state_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    iclass_e             iclass;
    logic                retire;

    opcode_class u_opcode_class (
        .opcode (opcode),
        .iclass (iclass)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        AluOp    = ALU_ADD;
        AluSrc   = 1'b0;
        Reg2Loc  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        IrWrite  = 1'b0;
        PcWrite  = 1'b0;
        PcSrc    = 1'b0;
        Illegal  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                // The instruction-register and PC loads must not fire while held in reset.
                IrWrite = MemReady && !rst;
                PcWrite = MemReady && !rst;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                Reg2Loc = (iclass == CLS_ST) || (iclass == CLS_CBZ);
                unique case (iclass)
                    CLS_R:         state_d = S_EXEC_R;
                    CLS_LD, CLS_ST: state_d = S_ADDR;
                    CLS_CBZ:       state_d = S_BRANCH;
                    CLS_B:         state_d = S_JUMP;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                AluOp   = ALU_RTYPE;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                AluOp    = ALU_RTYPE;
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDR: begin
                AluSrc  = 1'b1;
                state_d = (iclass == CLS_LD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                AluSrc  = 1'b1;
                MemRead = 1'b1;
                if (MemReady) state_d = S_WB_LD;
            end
            S_WB_LD: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                AluSrc   = 1'b1;
                Reg2Loc  = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                AluOp   = ALU_PASSB;
                Reg2Loc = 1'b1;
                PcSrc   = 1'b1;
                PcWrite = Zero;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                PcSrc   = 1'b1;
                PcWrite = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                Illegal = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;
    assign Retired   = retired_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomised bench: each instruction is expanded into its expected per-cycle trace
// (inputs + outputs), replayed against the DUT and compared every cycle.
module tb_main_control_fsm;

    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [10:0] T_CBZ  = 11'b10110100101;
    localparam logic [10:0] T_B    = 11'b00010111010;

    typedef struct packed {
        logic [1:0] aluop;
        logic alusrc, reg2loc, memread, memwrite, memtoreg;
        logic regwrite, irwrite, pcwrite, pcsrc, illegal;
    } outs_t;

    typedef struct {
        logic        rst, mr, z;
        logic [10:0] op;
        outs_t       exp;
        logic [31:0] ret;
    } step_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] opcode;
    logic        Zero, MemReady;
    logic [1:0]  AluOp;
    logic        AluSrc, Reg2Loc, MemRead, MemWrite, MemToReg, RegWrite;
    logic        IrWrite, PcWrite, PcSrc, Illegal;
    logic [31:0] Retired;

    int          errors = 0;
    int          checks = 0;
    step_t       tr[$];
    step_t       cur;
    bit          active = 1'b0;
    int          cyc = 0;
    logic [31:0] model_ret = 0;

    main_control_fsm #(.RETIRE_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .Zero(Zero), .MemReady(MemReady),
        .AluOp(AluOp), .AluSrc(AluSrc), .Reg2Loc(Reg2Loc), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .IrWrite(IrWrite), .PcWrite(PcWrite), .PcSrc(PcSrc), .Illegal(Illegal),
        .Retired(Retired)
    );

    always #5 clk = ~clk;

    // 0=R 1=LD 2=ST 3=CBZ 4=B 5=illegal
    function automatic int classify(input logic [10:0] op);
        if (op == T_ADD || op == T_SUB || op == T_AND || op == T_ORR) return 0;
        if (op == T_LDUR) return 1;
        if (op == T_STUR) return 2;
        if (op ==? 11'b10110100???) return 3;
        if (op ==? 11'b000101?????) return 4;
        return 5;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic r, input logic mr, input logic z,
                        input logic [10:0] op, input outs_t o);
        step_t s;
        s.rst = r; s.mr = mr; s.z = z; s.op = op; s.exp = o;
        s.ret = r ? 32'd0 : model_ret;
        tr.push_back(s);
    endtask

    task automatic add_reset(input logic mr);
        outs_t o;
        o = '0; o.memread = 1'b1;
        push(1'b1, mr, rb(), 11'($urandom), o);
        model_ret = 0;
    endtask

    // Expands one instruction into its cycles. abort: stop inside the memory
    // wait without completing. trapn: cycles spent in TRAP before a reset.
    task automatic add_instr(input logic [10:0] op, input int fw, input int mw,
                             input logic z, input bit abort, input int trapn);
        outs_t o;
        int    cls;
        cls = classify(op);
        for (int i = 0; i < fw; i++) begin
            o = '0; o.memread = 1'b1;
            push(1'b0, 1'b0, rb(), 11'($urandom), o);
        end
        o = '0; o.memread = 1'b1; o.irwrite = 1'b1; o.pcwrite = 1'b1;
        push(1'b0, 1'b1, rb(), op, o);
        o = '0; o.reg2loc = (cls == 2 || cls == 3);
        push(1'b0, rb(), rb(), op, o);
        case (cls)
            0: begin
                o = '0; o.aluop = 2'b10;
                push(1'b0, rb(), rb(), op, o);
                o.regwrite = 1'b1;
                push(1'b0, rb(), rb(), op, o);
                model_ret++;
            end
            1, 2: begin
                o = '0; o.alusrc = 1'b1;
                push(1'b0, rb(), rb(), op, o);
                if (cls == 1) o.memread = 1'b1;
                else begin o.memwrite = 1'b1; o.reg2loc = 1'b1; end
                for (int i = 0; i < mw; i++) push(1'b0, 1'b0, rb(), op, o);
                if (!abort) begin
                    push(1'b0, 1'b1, rb(), op, o);
                    if (cls == 2) model_ret++;
                    else begin
                        o = '0; o.regwrite = 1'b1; o.memtoreg = 1'b1;
                        push(1'b0, rb(), rb(), op, o);
                        model_ret++;
                    end
                end
            end
            3: begin
                o = '0; o.aluop = 2'b01; o.reg2loc = 1'b1; o.pcsrc = 1'b1; o.pcwrite = z;
                push(1'b0, rb(), z, op, o);
                model_ret++;
            end
            4: begin
                o = '0; o.pcsrc = 1'b1; o.pcwrite = 1'b1;
                push(1'b0, rb(), rb(), op, o);
                model_ret++;
            end
            default: begin
                o = '0; o.illegal = 1'b1;
                for (int i = 0; i < trapn; i++) push(1'b0, rb(), rb(), 11'($urandom), o);
                add_reset(rb());
            end
        endcase
    endtask

    // Entered and left at posedge+1; outputs are compared on the negedge.
    task automatic run_trace();
        foreach (tr[i]) begin
            rst = tr[i].rst; MemReady = tr[i].mr; Zero = tr[i].z; opcode = tr[i].op;
            cur = tr[i];
            active = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            cyc++;
        end
        active = 1'b0;
        tr.delete();
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            outs_t got;
            got = {AluOp, AluSrc, Reg2Loc, MemRead, MemWrite, MemToReg,
                   RegWrite, IrWrite, PcWrite, PcSrc, Illegal};
            checks++;
            if (got !== cur.exp) begin
                errors++;
                $display("FAIL outputs cyc=%0d op=%b mr=%b rst=%b: got %b expected %b",
                         cyc, cur.op, cur.mr, cur.rst, got, cur.exp);
            end
            checks++;
            if (Retired !== cur.ret) begin
                errors++;
                $display("FAIL retired cyc=%0d: got %0d expected %0d", cyc, Retired, cur.ret);
            end
        end
    end

    initial begin
        int n0;
        logic [10:0] rops [4];
        rops[0] = T_ADD; rops[1] = T_SUB; rops[2] = T_AND; rops[3] = T_ORR;
        rst = 1'b1; MemReady = 1'b1; Zero = 1'b0; opcode = '0;
        @(posedge clk);
        #1;

        // Reset with MemReady high, then a single ADD.
        add_reset(1'b1);
        n0 = tr.size();
        add_instr(T_ADD, 0, 0, 1'b0, 1'b0, 0);
        check_lit("add_len", 32'(tr.size() - n0), 32'd4);
        run_trace();
        check_lit("retired_after_add", Retired, 32'd1);

        // LDUR with 3 memory waits, stalled STUR fetch, CBZ taken/not taken, B.
        n0 = tr.size();
        add_instr(T_LDUR, 0, 3, 1'b0, 1'b0, 0);
        check_lit("ldur_len", 32'(tr.size() - n0), 32'd8);
        n0 = tr.size();
        add_instr(T_STUR, 2, 0, 1'b0, 1'b0, 0);
        check_lit("stur_len", 32'(tr.size() - n0), 32'd6);
        n0 = tr.size();
        add_instr(T_CBZ, 0, 0, 1'b1, 1'b0, 0);
        add_instr(T_CBZ, 0, 0, 1'b0, 1'b0, 0);
        check_lit("cbz_len", 32'(tr.size() - n0), 32'd6);
        n0 = tr.size();
        add_instr(T_B, 0, 0, 1'b0, 1'b0, 0);
        check_lit("b_len", 32'(tr.size() - n0), 32'd3);
        run_trace();
        check_lit("retired_after_directed", Retired, 32'd6);

        // Illegal opcode: trap for 12 cycles, then a reset pulse.
        add_instr(11'b00000000000, 0, 0, 1'b0, 1'b0, 12);
        run_trace();
        check_lit("illegal_cleared", 32'(Illegal), 32'd0);
        check_lit("retired_after_trap_reset", Retired, 32'd0);

        // Reset in MEM_WR while memory is still busy.
        add_instr(T_ADD, 0, 0, 1'b0, 1'b0, 0);
        add_instr(T_STUR, 0, 2, 1'b0, 1'b1, 0);
        add_reset(1'b0);
        run_trace();
        check_lit("abort_memwrite", 32'(MemWrite), 32'd0);
        check_lit("abort_retired", Retired, 32'd0);

        // Random instruction mix with random memory latencies.
        for (int k = 0; k < 300; k++) begin
            logic [10:0] op;
            int r;
            r = $urandom_range(0, 15);
            case (r)
                0, 1, 2, 3: op = rops[$urandom_range(0, 3)];
                4, 5:       op = T_LDUR;
                6, 7:       op = T_STUR;
                8, 9, 10:   op = {8'b10110100, 3'($urandom)};
                11, 12, 13: op = {6'b000101, 5'($urandom)};
                default:    op = 11'($urandom);
            endcase
            add_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), rb(), 1'b0,
                      $urandom_range(2, 5));
        end
        run_trace();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
